// File: rtl/mips_pkg.sv
// mips_pkg: shared store-size and store FSM encodings for the memory write path.
package mips_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} storeSize_e;
  typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, RESP = 2'b10} storeState_e;
  localparam int CNT_W = 8;
endpackage

// File: rtl/store_lane_steer.sv
// store_lane_steer: little-endian lane replication, byte enables and alignment check for a store.
module store_lane_steer
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] data,
  output logic [31:0] wData,
  output logic [3:0]  byteEn,
  output logic        misaligned
);
  always_comb begin
    wData = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
    byteEn = size == SZ_BYTE ? 4'b0001 << addrLo : size == SZ_HALF ? (addrLo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    misaligned = size == SZ_RSVD || (size == SZ_HALF && addrLo[0]) || (size == SZ_WORD && addrLo != 2'b00);
  end
endmodule

// File: rtl/store_narrower.sv
// store_narrower: turns a pipeline store into one word-aligned masked memory write with ack/timeout handling.
module store_narrower
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StoreReq,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        StoreReady,
  output logic        Stall,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  output logic        MemWrite,
  input  logic        MemAck,
  output logic        Done,
  output logic        AlignErr,
  output logic        BusErr
);
  storeState_e state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0] laneData;
  logic [3:0] laneEn, beReg;
  logic misaligned, accept, timedOut;

  store_lane_steer u_steer (
    .size(StoreSize),
    .addrLo(Addr[1:0]),
    .data(StoreData),
    .wData(laneData),
    .byteEn(laneEn),
    .misaligned(misaligned)
  );

  assign accept = state == IDLE && StoreReq && !misaligned;
  // an ack in the final wait cycle wins over the timeout
  assign timedOut = state == WRITE && !MemAck && waitCnt == CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = state;
    if (accept) nextState = WRITE;
    if (state == WRITE && (MemAck || timedOut)) nextState = MemAck ? RESP : IDLE;
    if (state == RESP) nextState = IDLE;
  end

  always_comb begin
    StoreReady = state == IDLE;
    Stall = state != IDLE;
    MemWrite = state == WRITE;
    MemByteEn = MemWrite ? beReg : 4'b0000;
    Done = state == RESP;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      waitCnt <= '0;
      MemAddr <= '0;
      MemWData <= '0;
      beReg <= '0;
      AlignErr <= 1'b0;
      BusErr <= 1'b0;
    end else begin
      waitCnt <= state == WRITE ? waitCnt + CNT_W'(1) : '0;
      AlignErr <= state == IDLE && StoreReq && misaligned;
      BusErr <= timedOut;
      if (accept) begin
        MemAddr <= {Addr[31:2], 2'b00};
        MemWData <= laneData;
        beReg <= laneEn;
      end
    end
endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower: scoreboard bench for store_narrower (TIMEOUT=4).
module tb_store_narrower;
  localparam int TO = 4;
  typedef enum {EV_WR, EV_DONE, EV_ALIGN, EV_BUS} ev_e;
  typedef struct {ev_e kind; logic [31:0] addr; logic [31:0] data; logic [3:0] be;} ev_t;

  logic clk = 0, reset = 1, StoreReq = 0, MemAck = 0;
  logic [1:0] StoreSize = 0;
  logic [31:0] Addr = 0, StoreData = 0;
  logic StoreReady, Stall, MemWrite, Done, AlignErr, BusErr;
  logic [31:0] MemAddr, MemWData;
  logic [3:0] MemByteEn;

  int checks = 0, failures = 0;
  ev_t expQ[$];
  logic prevWr = 0;
  logic [31:0] prevAddr = 0, prevData = 0;
  logic [3:0] prevBe = 0;
  int stallRun = 0, lastStall = 0, wrRun = 0, lastWr = 0;

  store_narrower #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .StoreReq(StoreReq), .StoreSize(StoreSize), .Addr(Addr),
    .StoreData(StoreData), .StoreReady(StoreReady), .Stall(Stall), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemByteEn(MemByteEn), .MemWrite(MemWrite), .MemAck(MemAck),
    .Done(Done), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expectEvent(input ev_e k);
    ev_t e;
    check("event_queued", 32'(expQ.size() != 0), 1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      check("event_kind", k, e.kind);
      if (k == EV_WR && e.kind == EV_WR) begin
        check("wr_addr", MemAddr, e.addr);
        check("wr_data", MemWData, e.data);
        check("wr_be", MemByteEn, e.be);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (MemWrite && !prevWr) expectEvent(EV_WR);
      if (MemWrite && prevWr) begin
        check("hold_addr", MemAddr, prevAddr);
        check("hold_data", MemWData, prevData);
        check("hold_be", MemByteEn, prevBe);
      end
      if (!MemWrite) check("be_zero_idle", MemByteEn, 0);
      if (Done) expectEvent(EV_DONE);
      if (AlignErr) expectEvent(EV_ALIGN);
      if (BusErr) expectEvent(EV_BUS);
      if (Stall) stallRun++;
      else if (stallRun != 0) begin lastStall = stallRun; stallRun = 0; end
      if (MemWrite) wrRun++;
      else if (wrRun != 0) begin lastWr = wrRun; wrRun = 0; end
    end else begin
      stallRun = 0;
      wrRun = 0;
    end
    prevWr = MemWrite;
    prevAddr = MemAddr;
    prevData = MemWData;
    prevBe = MemByteEn;
  end

  function automatic void model(input logic [1:0] sz, input logic [31:0] a, d,
                                output logic bad, output logic [31:0] wd, output logic [3:0] be);
    bad = 1; wd = d; be = 4'hF;
    case (sz)
      2'b00: begin bad = 0; wd = {4{d[7:0]}}; be = 4'b0001 << a[1:0]; end
      2'b01: begin bad = a[0]; wd = {2{d[15:0]}}; be = a[1] ? 4'b1100 : 4'b0011; end
      2'b10: begin bad = a[1:0] != 2'b00; wd = d; be = 4'b1111; end
      default: bad = 1;
    endcase
  endfunction

  task automatic doStore(input logic [1:0] sz, input logic [31:0] a, d, input int ackAfter);
    logic bad;
    logic [31:0] wd;
    logic [3:0] be;
    bit ok;
    model(sz, a, d, bad, wd, be);
    ok = ackAfter >= 0 && ackAfter < TO;
    for (int i = 0; i < 20 && !StoreReady; i++) begin @(posedge clk); #1; end
    check("ready_before_req", StoreReady, 1);
    if (bad) expQ.push_back('{EV_ALIGN, 0, 0, 0});
    else begin
      expQ.push_back('{EV_WR, {a[31:2], 2'b00}, wd, be});
      expQ.push_back('{ok ? EV_DONE : EV_BUS, 0, 0, 0});
    end
    StoreReq = 1; StoreSize = sz; Addr = a; StoreData = d;
    @(posedge clk); #1;
    StoreReq = 0;
    if (bad) begin
      check("no_write_on_align", MemWrite, 0);
      check("align_pulse", AlignErr, 1);
    end else begin
      for (int i = 0; i < TO; i++) begin
        MemAck = i == ackAfter;
        @(posedge clk); #1;
        MemAck = 0;
        if (i == ackAfter) break;
      end
      if (ok) check("done_after_ack", Done, 1);
      else begin
        check("ready_after_timeout", StoreReady, 1);
        check("buserr_pulse", BusErr, 1);
        check("no_write_after_timeout", MemWrite, 0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", StoreReady, 1);
    check("rst_stall", Stall, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_be", MemByteEn, 0);
    check("rst_addr", MemAddr, 0);
    check("rst_wdata", MemWData, 0);
    check("rst_flags", {Done, AlignErr, BusErr}, 0);
    reset = 0;
    @(posedge clk); #1;

    doStore(2'b00, 32'h1003, 32'hAABBCCDD, 2);
    check("byte_stall_len", lastStall, 4);
    check("byte_wr_len", lastWr, 3);
    doStore(2'b01, 32'h2002, 32'h12345678, 0);
    doStore(2'b01, 32'h2001, 32'h12345678, 0);
    doStore(2'b10, 32'h3000, 32'hDEADBEEF, 0);
    check("word_stall_len", lastStall, 2);
    doStore(2'b10, 32'h3004, 32'hCAFEF00D, -1);
    check("timeout_wr_len", lastWr, TO);
    doStore(2'b01, 32'h4000, 32'h0000BEEF, TO - 1);
    check("late_ack_wr_len", lastWr, TO);
    check("late_ack_stall_len", lastStall, TO + 1);
    doStore(2'b11, 32'h5000, 32'h11111111, 0);
    doStore(2'b10, 32'h5002, 32'h22222222, 0);
    for (int i = 0; i < 4; i++) doStore(2'b00, 32'h100 + i, $urandom, i % 3);
    for (int i = 0; i < 4; i++) doStore(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 4));

    MemAck = 1;
    @(posedge clk); #1;
    MemAck = 0;
    check("ack_idle_ignored", {StoreReady, Stall}, 2'b10);
    repeat (2) @(posedge clk);
    #1;

    expQ.push_back('{EV_WR, 32'h6000, 32'h33333333, 4'hF});
    StoreReq = 1; StoreSize = 2'b10; Addr = 32'h6000; StoreData = 32'h33333333;
    @(posedge clk); #1;
    StoreReq = 0;
    @(negedge clk);
    check("write_before_reset", MemWrite, 1);
    #2 reset = 1;
    #1;
    check("reset_drops_write", MemWrite, 0);
    check("reset_drops_stall", Stall, 0);
    check("reset_ready", StoreReady, 1);
    check("reset_no_resp", {Done, BusErr}, 0);
    @(posedge clk); #1;
    reset = 0;
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_narrower.md
STORE_NARROWER -- requirements
Module: store_narrower

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum cycles WRITE waits for MemAck before aborting (range 1..255).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port StoreReq  input  1  SHALL be the pipeline's store request, sampled only while StoreReady=1.
REQ-005 Port StoreSize  input  2  SHALL encode the access width: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-006 Port Addr  input  32  SHALL be the byte address of the store.
REQ-007 Port StoreData  input  32  SHALL be the full register value (rt) to be narrowed.
REQ-008 Port StoreReady  output  1  SHALL be high when a request can be accepted this cycle.
REQ-009 Port Stall  output  1  SHALL be high while a store is in flight (pipeline hold).
REQ-010 Port MemAddr  output  32  SHALL be the word-aligned address {Addr[31:2],2'b00}.
REQ-011 Port MemWData  output  32  SHALL be the lane-steered write data.
REQ-012 Port MemByteEn  output  4  SHALL be the byte-lane enables, bit i for byte lane i.
REQ-013 Port MemWrite  output  1  SHALL be the memory write strobe.
REQ-014 Port MemAck  input  1  SHALL be the memory's one-cycle write acknowledge.
REQ-015 Port Done  output  1  SHALL pulse one cycle on successful completion.
REQ-016 Port AlignErr  output  1  SHALL pulse one cycle for a misaligned or reserved-size request.
REQ-017 Port BusErr  output  1  SHALL pulse one cycle on timeout.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, RESP; StoreReady=1 only in IDLE.
REQ-019 In IDLE with StoreReq=1: misaligned (half with Addr[0]=1, word with Addr[1:0]!=0) or size 11 SHALL stay IDLE, pulse AlignErr next cycle, never assert MemWrite.
REQ-020 In IDLE with a valid request: Addr/data/enables SHALL be registered and state SHALL move to WRITE; MemWrite rises the next cycle (1-cycle latency).
REQ-021 Lane steering, little-endian: byte -> MemWData={4{StoreData[7:0]}}, MemByteEn=4'b0001<<Addr[1:0]; half -> {2{StoreData[15:0]}}, 4'b0011 (Addr[1]=0) or 4'b1100 (Addr[1]=1); word -> StoreData, 4'b1111.
REQ-022 In WRITE, MemWrite, MemAddr, MemWData, MemByteEn SHALL be held stable until MemAck=1 or timeout.
REQ-023 MemAck=1 in WRITE SHALL move to RESP; RESP SHALL pulse Done for exactly one cycle and return to IDLE.
REQ-024 Wait counter SHALL clear on WRITE entry and increment each WRITE cycle without MemAck; reaching TIMEOUT SHALL drop MemWrite, pulse BusErr, return IDLE.
REQ-025 MemAck and timeout in the same cycle SHALL resolve as success (Done, no BusErr).
REQ-026 MemAck outside WRITE SHALL be ignored.
REQ-027 Stall SHALL be high in WRITE and RESP, low in IDLE.
REQ-028 MemByteEn SHALL be 4'b0000 whenever MemWrite=0.

Reset
REQ-029 Reset SHALL force IDLE, counter 0, MemWrite/Done/AlignErr/BusErr/Stall=0, MemByteEn=0, MemAddr=0, MemWData=0, StoreReady=1.
REQ-030 Reset asserted mid-WRITE SHALL drop MemWrite immediately (asynchronously) with no Done or BusErr.

Structure
REQ-031 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding SHALL live in the shared package mips_pkg.
REQ-032 Lane steering and alignment check SHALL be one combinational sub-module, store_lane_steer; FSM and counter remain in store_narrower.

Verification
REQ-033 Byte store, Addr=0x1003, StoreData=0xAABBCCDD, ack after 2 cycles -> MemAddr=0x1000, MemWData=0xDDDDDDDD, MemByteEn=1000, Done one cycle after ack.
REQ-034 Half store, Addr=0x2002, StoreData=0x12345678 -> MemWData=0x56785678, MemByteEn=1100; Addr=0x2001 -> AlignErr pulse, MemWrite never high.
REQ-035 Word store, Addr=0x3000, StoreData=0xDEADBEEF, ack in first WRITE cycle -> MemByteEn=1111, Stall high exactly 2 cycles.
REQ-036 TIMEOUT=4, no MemAck -> MemWrite high 4 cycles, then BusErr pulse, StoreReady=1 next cycle; ack arriving on the 4th cycle -> Done, no BusErr.
REQ-037 Reset asserted during WRITE -> MemWrite=0 same cycle, no Done/BusErr; StoreSize=11 -> AlignErr pulse.
